axi_slave_ram: RTL and testbench
================================

Name: axi_slave_ram

Overview:
- Synthesizable AXI4 (INCR-burst subset) slave memory that answers the core's instruction/data master ports.
- Replaces the behavioural slave BFM for FPGA builds and gate-level runs.
- One instance per port (inst, data), each backed by on-chip block RAM.
- One outstanding transaction at a time; reads and writes arbitrated fairly.

Parameters:
- C_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_OFFSET_WIDTH, 28, AWADDR/ARADDR width in bits.
- C_MEM_WORDS, 2048, memory depth in 32-bit words; must be a power of two.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- AWADDR  in  C_OFFSET_WIDTH  write burst start byte address.
- AWLEN  in  8  write beats minus 1.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit k enables WDATA[8k+7:8k].
- WLAST  in  1  master's last-beat flag.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  C_OFFSET_WIDTH  read burst start byte address.
- ARLEN  in  8  read beats minus 1.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response; always 2'b00.
- RLAST  out  1  final read beat.
- RVALID / RREADY  out / in  1  read-data handshake.

Behaviour:
- Reset: asynchronous on RST_N low.
  - All outputs go to 0 and the FSM goes to IDLE; the arbitration pointer selects read.
  - Memory contents are not cleared.
- Reset mid-burst: the burst is abandoned with no B or R response, and a new transaction is accepted after RST_N rises.
- Memory is the array ram_array[0:C_MEM_WORDS-1] of 32-bit words, hierarchically accessible for bench preload.
- Word index = addr[C_OFFSET_WIDTH-1:2] modulo C_MEM_WORDS.
  - Address bits [1:0] are ignored.
  - Incrementing past the top of memory wraps to index 0.
- Burst type is always INCR with 4-byte beats; the beat count is LEN+1, from 1 to 256.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - AWREADY and ARREADY are registered pulses.
  - If only AWVALID is high: pulse AWREADY for 1 cycle, latch AWADDR/AWLEN, go to WDATA.
  - If only ARVALID is high: pulse ARREADY, latch, go to RDATA.
  - If both are high: serve the channel the pointer selects, then toggle the pointer. The losing request stays pending and is served next.
- WDATA:
  - WREADY=1.
  - Each WVALID&WREADY beat writes the bytes enabled by WSTRB at the current index, then increments the index and beat counter.
  - The beat with counter==LEN is final: WREADY drops next cycle, go to WRESP.
  - Termination depends on the counter only. If WLAST is inconsistent with the counter on any beat, record an error.
- WRESP:
  - BVALID=1; BRESP=2'b10 (SLVERR) if an error was recorded, else 2'b00.
  - On BREADY the FSM returns to IDLE.
  - The next AWREADY/ARREADY comes no earlier than 1 cycle after the B handshake.
- RDATA:
  - The RAM read is synchronous with 1-cycle latency.
  - First RVALID occurs 2 cycles after the AR handshake cycle.
  - With RREADY held high, beats come on consecutive cycles (1 beat/clock).
  - RDATA/RLAST stay stable while RVALID && !RREADY; prefetch is held in a skid register.
  - RLAST=1 only on beat LEN.
  - After the last-beat handshake, RVALID drops and the FSM goes to IDLE.
- A write followed by a read of the same address returns the new data; there is no hazard, because transactions are serialized.

Test Plan:
1. Write single beat: AWADDR=0x10, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=0xF. Read ARADDR=0x10, ARLEN=0. -> BRESP=0; RDATA=0xDEADBEEF; RLAST=1; RVALID 2 cycles after AR handshake.
2. Bench preloads ram_array[i]=i. Read ARADDR=0x40, ARLEN=15, RREADY held high. -> RDATA 16..31 on 16 consecutive cycles; RLAST only on 31.
3. Preload 0x11223344 at word 5. Write WSTRB=4'b0101, WDATA=0xAABBCCDD. -> read returns 0x11BB33DD.
4. Read burst ARLEN=7 from word C_MEM_WORDS-4, RREADY toggling 1,0,0,1. -> data from words 2044..2047 then 0..3; RDATA held during stalls; no beat lost or duplicated.
5. AWVALID and ARVALID asserted the same cycle after reset. -> read served first, then write. Repeat the pair -> write served first.
6. Write AWLEN=3 with WLAST asserted on beat 2. -> BRESP=2'b10; 4 beats written. Separately, deassert RST_N during beat 2 of an 8-beat read. -> RVALID=0 immediately; the next transaction completes normally.

Source files
------------

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 INCR-burst slave backed by one on-chip block RAM.
// One transaction in flight at a time; simultaneous AW/AR requests alternate via a toggling pointer.
module axi_slave_ram #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_MEM_WORDS      = 2048
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                    ARLEN,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam int NB    = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t state_q, state_d;

  logic [C_AXI_DATA_WIDTH-1:0] ram_array [0:C_MEM_WORDS-1];
  logic [C_AXI_DATA_WIDTH-1:0] ram_q;

  logic [IDX_W-1:0] idx_q;
  logic [8:0]       cnt_q;
  logic [7:0]       len_q;
  logic             err_q;
  logic             aw_ready_q, ar_ready_q;
  logic             rd_pri_q;
  logic             r_valid_q, r_last_q;

  logic aw_ready_d, ar_ready_d, toggle_pri;
  logic we, rd_en;
  logic aw_hs, ar_hs, last_beat, fetch_more, pick_w, pick_r;
  logic unused_addr_bits;

  assign aw_hs      = (state_q == S_IDLE) && aw_ready_q && AWVALID;
  assign ar_hs      = (state_q == S_IDLE) && ar_ready_q && ARVALID;
  assign last_beat  = (cnt_q == {1'b0, len_q});
  assign fetch_more = (cnt_q <= {1'b0, len_q});
  assign pick_w     = AWVALID && (!ARVALID || !rd_pri_q);
  assign pick_r     = ARVALID && (!AWVALID || rd_pri_q);

  assign unused_addr_bits = ^{AWADDR[C_OFFSET_WIDTH-1:IDX_W+2], AWADDR[1:0],
                              ARADDR[C_OFFSET_WIDTH-1:IDX_W+2], ARADDR[1:0]};

  always_comb begin
    state_d    = state_q;
    aw_ready_d = 1'b0;
    ar_ready_d = 1'b0;
    toggle_pri = 1'b0;
    we         = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A ready pulse is already out: this cycle is the handshake slot, never re-arbitrate
        if (aw_ready_q || ar_ready_q) begin
          if (aw_hs)
            state_d = S_WDATA;
          else if (ar_hs)
            state_d = S_RDATA;
        end else if (pick_w) begin
          aw_ready_d = 1'b1;
          toggle_pri = ARVALID;
        end else if (pick_r) begin
          ar_ready_d = 1'b1;
          toggle_pri = AWVALID;
        end
      end
      S_WDATA: begin
        if (WVALID) begin
          we = 1'b1;
          if (last_beat)
            state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (BREADY)
          state_d = S_IDLE;
      end
      S_RDATA: begin
        // Fetch only when the held beat is empty or leaving, so ram_q doubles as the skid
        rd_en = fetch_more && (!r_valid_q || RREADY);
        if (r_valid_q && RREADY && r_last_q)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      rd_pri_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= aw_ready_d;
      ar_ready_q <= ar_ready_d;
      if (toggle_pri)
        rd_pri_q <= ~rd_pri_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        idx_q <= AWADDR[IDX_W+1:2];
        len_q <= AWLEN;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (ar_hs) begin
        idx_q <= ARADDR[IDX_W+1:2];
        len_q <= ARLEN;
        cnt_q <= '0;
      end else if (we || rd_en) begin
        idx_q <= idx_q + IDX_W'(1);
        cnt_q <= cnt_q + 9'd1;
      end

      // Burst length is governed by the counter; WLAST is only cross-checked
      if (we && (WLAST != last_beat))
        err_q <= 1'b1;

      if (rd_en) begin
        r_valid_q <= 1'b1;
        r_last_q  <= last_beat;
      end else if (r_valid_q && RREADY) begin
        r_valid_q <= 1'b0;
        r_last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (WSTRB[b])
          ram_array[idx_q][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
    if (rd_en)
      ram_q <= ram_array[idx_q];
  end

  assign AWREADY = aw_ready_q;
  assign ARREADY = ar_ready_q;
  assign WREADY  = (state_q == S_WDATA);
  assign BVALID  = (state_q == S_WRESP);
  assign BRESP   = ((state_q == S_WRESP) && err_q) ? 2'b10 : 2'b00;
  assign RVALID  = r_valid_q;
  assign RLAST   = r_last_q;
  assign RRESP   = 2'b00;
  // RAM output register has no reset, so RDATA is masked to read as zero when idle
  assign RDATA   = r_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed AXI bursts against axi_slave_ram with a queue scoreboard.
// Stimulus tasks push expected R beats, B responses and grant order; a negedge monitor pops and compares.
module tb_axi_slave_ram;

  localparam int AW = 28;
  localparam int MW = 2048;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic [7:0]    AWLEN = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WLAST = 1'b0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;

  axi_slave_ram #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(AW), .C_MEM_WORDS(MW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [32:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic        exp_grant[$];
  logic [31:0] wr_data [0:255];
  logic [31:0] rd_exp  [0:255];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every handshake pops its expectation; held beats must not change during stalls
  logic        first_r_pending = 1'b0;
  int          ar_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge CLK) begin
    logic [32:0] e;
    if (!RST_N) begin
      first_r_pending = 1'b0;
      prev_stall      = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("r_hold_valid", 32'(RVALID), 32'd1);
        check_output("r_hold_data", RDATA, prev_data);
        check_output("r_hold_last", 32'(RLAST), 32'(prev_last));
      end
      if (ARVALID && ARREADY) begin
        ar_cyc = cyc;
        first_r_pending = 1'b1;
        if (exp_grant.size() == 0) check_output("grant_unexpected_ar", 32'd1, 32'd0);
        else check_output("grant_order", 32'd1, 32'(exp_grant.pop_front()));
      end
      if (AWVALID && AWREADY) begin
        if (exp_grant.size() == 0) check_output("grant_unexpected_aw", 32'd1, 32'd0);
        else check_output("grant_order", 32'd0, 32'(exp_grant.pop_front()));
      end
      if (RVALID && first_r_pending) begin
        check_output("r_first_latency", 32'(cyc - ar_cyc), 32'd2);
        first_r_pending = 1'b0;
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) check_output("r_unexpected_beat", 32'd1, 32'd0);
        else begin
          e = exp_r.pop_front();
          check_output("r_data", RDATA, e[31:0]);
          check_output("r_last", 32'(RLAST), 32'(e[32]));
          check_output("r_resp", 32'(RRESP), 32'd0);
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) check_output("b_unexpected", 32'd1, 32'd0);
        else check_output("b_resp", 32'(BRESP), 32'(exp_b.pop_front()));
      end
      prev_stall = RVALID && !RREADY;
      prev_data  = RDATA;
      prev_last  = RLAST;
    end
  end

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check_output("rst_awready", 32'(AWREADY), 32'd0);
    check_output("rst_arready", 32'(ARREADY), 32'd0);
    check_output("rst_wready", 32'(WREADY), 32'd0);
    check_output("rst_bvalid", 32'(BVALID), 32'd0);
    check_output("rst_bresp", 32'(BRESP), 32'd0);
    check_output("rst_rvalid", 32'(RVALID), 32'd0);
    check_output("rst_rlast", 32'(RLAST), 32'd0);
    check_output("rst_rdata", RDATA, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic apply_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [3:0] strb,
                             input int wlast_at, input logic [1:0] bresp);
    bit ok;
    exp_b.push_back(bresp);
    AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (AWREADY) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    if (!ok) begin check_output("aw_timeout", 32'd0, 32'd1); return; end
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wr_data[b]; WSTRB = strb; WLAST = (b == wlast_at); WVALID = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge CLK);
        if (WREADY) begin ok = 1'b1; break; end
      end
      @(posedge CLK); #1;
      if (!ok) begin WVALID = 1'b0; check_output("w_timeout", 32'd0, 32'd1); return; end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (BVALID) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1;
    BREADY = 1'b0;
    if (!ok) check_output("b_timeout", 32'd0, 32'd1);
  endtask

  // pat[k%4] drives RREADY on the k-th cycle after the AR handshake
  task automatic apply_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [3:0] pat);
    bit ok;
    int beats, first_c, last_c, k;
    for (int i = 0; i <= int'(len); i++) exp_r.push_back({(i == int'(len)), rd_exp[i]});
    ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (ARREADY) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    if (!ok) begin check_output("ar_timeout", 32'd0, 32'd1); return; end
    beats = 0; first_c = 0; last_c = 0; k = 0;
    for (int t = 0; t < 1000 && beats <= int'(len); t++) begin
      RREADY = pat[k % 4];
      @(negedge CLK);
      if (RVALID && RREADY) begin
        if (beats == 0) first_c = cyc;
        last_c = cyc;
        beats++;
      end
      @(posedge CLK); #1;
      k++;
    end
    RREADY = 1'b0;
    check_output("r_beat_count", 32'(beats), 32'(int'(len) + 1));
    if (pat == 4'hF) check_output("r_back_to_back", 32'(last_c - first_c), 32'(len));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    for (int i = 0; i < MW; i++) dut.ram_array[i] = i;
    apply_reset();

    // 1: single-beat write then read-back
    wr_data[0] = 32'hDEADBEEF;
    exp_grant.push_back(1'b0);
    apply_write(28'h10, 8'd0, 4'hF, 0, 2'b00);
    rd_exp[0] = 32'hDEADBEEF;
    exp_grant.push_back(1'b1);
    apply_read(28'h10, 8'd0, 4'hF);

    // 2: 16-beat read of preloaded words 16..31 at full rate
    for (int i = 0; i < 16; i++) rd_exp[i] = 32'(16 + i);
    exp_grant.push_back(1'b1);
    apply_read(28'h40, 8'd15, 4'hF);

    // 3: partial byte strobes merge with preloaded word
    dut.ram_array[5] = 32'h11223344;
    wr_data[0] = 32'hAABBCCDD;
    exp_grant.push_back(1'b0);
    apply_write(28'h14, 8'd0, 4'b0101, 0, 2'b00);
    rd_exp[0] = 32'h11BB33DD;
    exp_grant.push_back(1'b1);
    apply_read(28'h14, 8'd0, 4'hF);

    // 4: read wrapping past the top of memory with RREADY 1,0,0,1
    rd_exp[0] = 32'd2044; rd_exp[1] = 32'd2045; rd_exp[2] = 32'd2046; rd_exp[3] = 32'd2047;
    rd_exp[4] = 32'd0;    rd_exp[5] = 32'd1;    rd_exp[6] = 32'd2;    rd_exp[7] = 32'd3;
    exp_grant.push_back(1'b1);
    apply_read(28'h1FF0, 8'd7, 4'b1001);

    // 5: simultaneous AW/AR after reset: read wins, then write; next pair write wins
    apply_reset();
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    wr_data[0] = 32'h0000_0055;
    rd_exp[0]  = 32'd200;
    fork
      apply_write(28'd400, 8'd0, 4'hF, 0, 2'b00);
      apply_read(28'd800, 8'd0, 4'hF);
    join
    rd_exp[0] = 32'h0000_0055;
    exp_grant.push_back(1'b1);
    apply_read(28'd400, 8'd0, 4'hF);
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    wr_data[0] = 32'h0000_0066;
    rd_exp[0]  = 32'd201;
    fork
      apply_write(28'd404, 8'd0, 4'hF, 0, 2'b00);
      apply_read(28'd804, 8'd0, 4'hF);
    join
    rd_exp[0] = 32'h0000_0066;
    exp_grant.push_back(1'b1);
    apply_read(28'd404, 8'd0, 4'hF);

    // 6a: WLAST on beat 2 of a 4-beat write -> SLVERR, yet all 4 beats land
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0DE0000 + 32'(i);
    exp_grant.push_back(1'b0);
    apply_write(28'h100, 8'd3, 4'hF, 2, 2'b10);
    for (int i = 0; i < 4; i++) rd_exp[i] = 32'hC0DE0000 + 32'(i);
    exp_grant.push_back(1'b1);
    apply_read(28'h100, 8'd3, 4'hF);

    // 6b: reset while beat 2 of an 8-beat read is on the bus
    exp_grant.push_back(1'b1);
    exp_r.push_back({1'b0, 32'd300});
    exp_r.push_back({1'b0, 32'd301});
    ARADDR = 28'd1200; ARLEN = 8'd7; ARVALID = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (ARREADY) break;
    end
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    RREADY = 1'b1;
    beats = 0;
    for (int t = 0; t < 50 && beats < 2; t++) begin
      @(negedge CLK);
      if (RVALID && RREADY) beats++;
      @(posedge CLK); #1;
    end
    check_output("rst_mid_beats_before", 32'(beats), 32'd2);
    check_output("rst_mid_beat2_shown", 32'(RVALID), 32'd1);
    RST_N = 1'b0;
    #1;
    check_output("rst_mid_rvalid_drop", 32'(RVALID), 32'd0);
    check_output("rst_mid_rlast_drop", 32'(RLAST), 32'd0);
    @(posedge CLK); #1;
    RREADY = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rd_exp[0] = 32'd400; rd_exp[1] = 32'd401;
    exp_grant.push_back(1'b1);
    apply_read(28'd1600, 8'd1, 4'hF);

    repeat (4) @(posedge CLK);
    #1;
    check_output("left_r_expect", 32'(exp_r.size()), 32'd0);
    check_output("left_b_expect", 32'(exp_b.size()), 32'd0);
    check_output("left_grant_expect", 32'(exp_grant.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
